// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the ALU sequencer slice.
//   State encoding, command kinds and default widths used by
//   alu_sequencer and alu_seq_regfile.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREGS = 4;
    localparam int DEF_AW    = 2;
    localparam int DEF_OPW   = 4;
    localparam int DEF_CCW   = 2;

    localparam logic [1:0] KIND_RR    = 2'd0;
    localparam logic [1:0] KIND_RI    = 2'd1;
    localparam logic [1:0] KIND_LOADI = 2'd2;
    localparam logic [1:0] KIND_NOP   = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        EXEC2 = 3'd3,
        WB    = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREGS x WIDTH register file, async active-low reset to 0.
//   clk, rst_n           clock / asynchronous active-low reset
//   i_we, i_waddr, i_wdata  single write port
//   i_ra, o_rd_a         read port A (combinational)
//   i_rb, o_rd_b         read port B (combinational)
//   i_rdbg, o_rd_dbg     debug read port (combinational)
module alu_seq_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_ra,
    input  logic [AW-1:0]    i_rb,
    input  logic [AW-1:0]    i_rdbg,
    output logic [WIDTH-1:0] o_rd_a,
    output logic [WIDTH-1:0] o_rd_b,
    output logic [WIDTH-1:0] o_rd_dbg
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rd_a   = r_mem[i_ra];
    assign o_rd_b   = r_mem[i_rb];
    assign o_rd_dbg = r_mem[i_rdbg];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven controller for the shared external 8-bit ALU.
//   clk, rst_n                 clock / asynchronous active-low reset
//   cmd_valid, cmd_ready       command handshake (ready only in IDLE)
//   cmd_kind/op/dst/src_a/src_b/imm  command fields, latched at handshake
//   alu_a, alu_b, alu_op       registered drive to the ALU
//   alu_e, alu_cc              ALU result and condition code
//   res_valid, res_data        one-cycle completion pulse / last written value
//   flags                      last ALU cc captured
//   dbg_addr, dbg_data         combinational register-file peek
// Optional macro ALU_SEQ_OUTREG_EN: adds EXEC2, registering the ALU result
// one extra cycle before commit (ALU-kind latency N+4 instead of N+3).
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int OPW   = DEF_OPW,
    parameter int CCW   = DEF_CCW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_e,
    input  logic [CCW-1:0]   alu_cc,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [CCW-1:0]   flags,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           r_state, w_next;
    logic             w_hs, w_we;
    logic [1:0]       r_kind;
    logic [OPW-1:0]   r_op;
    logic [AW-1:0]    r_dst, r_src_a, r_src_b;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_alu_a, r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_res_data;
    logic [CCW-1:0]   r_flags;
    logic [WIDTH-1:0] w_rd_a, w_rd_b;
`ifdef ALU_SEQ_OUTREG_EN
    logic [WIDTH-1:0] r_e_q;
    logic [CCW-1:0]   r_cc_q;
`endif

    assign w_hs = cmd_valid & cmd_ready;
    // r_res_data already holds the value to commit when WB is reached
    assign w_we = (r_state == WB) && (r_kind != KIND_NOP);

    alu_seq_regfile #(
        .WIDTH(WIDTH),
        .NREGS(NREGS),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_dst),
        .i_wdata (r_res_data),
        .i_ra    (r_src_a),
        .i_rb    (r_src_b),
        .i_rdbg  (dbg_addr),
        .o_rd_a  (w_rd_a),
        .o_rd_b  (w_rd_b),
        .o_rd_dbg(dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hs ? ((cmd_kind == KIND_NOP) ? WB : READ) : IDLE;
            READ:    w_next = (r_kind == KIND_LOADI) ? WB : EXEC;
`ifdef ALU_SEQ_OUTREG_EN
            EXEC:    w_next = EXEC2;
`else
            EXEC:    w_next = WB;
`endif
            EXEC2:   w_next = WB;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        res_valid = (r_state == WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind     <= '0;
            r_op       <= '0;
            r_dst      <= '0;
            r_src_a    <= '0;
            r_src_b    <= '0;
            r_imm      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res_data <= '0;
            r_flags    <= '0;
`ifdef ALU_SEQ_OUTREG_EN
            r_e_q      <= '0;
            r_cc_q     <= '0;
`endif
        end else begin
            if (w_hs) begin
                r_kind  <= cmd_kind;
                r_op    <= cmd_op;
                r_dst   <= cmd_dst;
                r_src_a <= cmd_src_a;
                r_src_b <= cmd_src_b;
                r_imm   <= cmd_imm;
            end
            if (r_state == READ && r_kind == KIND_LOADI) r_res_data <= r_imm;
            // operands are sampled here, before any WB write, so src == dst reads the old value
            if (r_state == READ && r_kind != KIND_LOADI) begin
                r_alu_a  <= w_rd_a;
                r_alu_b  <= (r_kind == KIND_RR) ? w_rd_b : r_imm;
                r_alu_op <= r_op;
            end
`ifdef ALU_SEQ_OUTREG_EN
            if (r_state == EXEC) begin
                r_e_q  <= alu_e;
                r_cc_q <= alu_cc;
            end
            if (r_state == EXEC2) begin
                r_res_data <= r_e_q;
                r_flags    <= r_cc_q;
            end
`else
            if (r_state == EXEC) begin
                r_res_data <= alu_e;
                r_flags    <= alu_cc;
            end
`endif
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign res_data = r_res_data;
    assign flags    = r_flags;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven scoreboard bench for alu_sequencer with a stand-in ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_OUTREG_EN
    localparam int LAT_ALU = 4;
`else
    localparam int LAT_ALU = 3;
`endif

    logic       clk = 0, rst_n = 0;
    logic       cmd_valid = 0, cmd_ready;
    logic [1:0] cmd_kind = 0;
    logic [3:0] cmd_op = 0;
    logic [1:0] cmd_dst = 0, cmd_src_a = 0, cmd_src_b = 0;
    logic [7:0] cmd_imm = 0;
    logic [7:0] alu_a, alu_b, alu_e, res_data, dbg_data;
    logic [3:0] alu_op;
    logic [1:0] alu_cc, flags;
    logic       res_valid;
    logic [1:0] dbg_addr = 0;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] op;
        logic [1:0] dst, sa, sb;
        logic [7:0] imm;
        logic [7:0] data;
        logic [1:0] fl;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic [1:0] fl;
    } exp_t;

    exp_t q[$];
    vec_t tbl[10];
    int   cyc = 0, checks = 0, passes = 0, fails = 0;
    bit   mon_en = 0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a),
        .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_e(alu_e), .alu_cc(alu_cc), .res_valid(res_valid),
        .res_data(res_data), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // stand-in ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass A; cc = {carry/borrow, zero}
    function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] t;
        case (op)
            4'd0:    t = {1'b0, a} + {1'b0, b};
            4'd1:    t = {1'b0, a} - {1'b0, b};
            4'd2:    t = {1'b0, a & b};
            4'd3:    t = {1'b0, a | b};
            4'd4:    t = {1'b0, a ^ b};
            default: t = {1'b0, a};
        endcase
        return {t[8], t[7:0] == 8'd0, t[7:0]};
    endfunction

    assign {alu_cc, alu_e} = alu_f(alu_a, alu_b, alu_op);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end else passes++;
    endtask

    function automatic int lat(input logic [1:0] k);
        return (k == KIND_NOP) ? 1 : (k == KIND_LOADI) ? 2 : LAT_ALU;
    endfunction

    // entered and left at a negedge; leaves cmd_valid high so commands can run back-to-back
    task automatic send(input vec_t v);
        int n, hs;
        cmd_valid = 1;
        cmd_kind = v.kind; cmd_op = v.op; cmd_dst = v.dst;
        cmd_src_a = v.sa; cmd_src_b = v.sb; cmd_imm = v.imm;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("handshake_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            hs = cyc;
            @(posedge clk);
            #1;
            q.push_back('{due: hs + lat(v.kind), data: v.data, fl: v.fl});
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        cmd_valid = 0;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_res_valid", 32'(res_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("flags", 32'(flags), 32'(e.fl));
                end
            end else if (q.size() > 0) begin
                if (cyc > q[0].due) begin
                    chk("late_res_valid", cyc, q[0].due);
                    void'(q.pop_front());
                end else begin
                    chk("ready_while_busy", 32'(cmd_ready), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{KIND_LOADI, 4'd0, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 2'b00};
        tbl[1] = '{KIND_LOADI, 4'd0, 2'd2, 2'd0, 2'd0, 8'h02, 8'h02, 2'b00};
        tbl[2] = '{KIND_RR,    4'd0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h03, 2'b00};
        tbl[3] = '{KIND_RI,    4'd0, 2'd3, 2'd3, 2'd0, 8'hFF, 8'h02, 2'b10};
        tbl[4] = '{KIND_NOP,   4'd0, 2'd0, 2'd0, 2'd0, 8'h55, 8'h02, 2'b10};
        tbl[5] = '{KIND_RR,    4'd1, 2'd0, 2'd1, 2'd1, 8'h00, 8'h00, 2'b01};
        tbl[6] = '{KIND_LOADI, 4'd0, 2'd0, 2'd0, 2'd0, 8'hA5, 8'hA5, 2'b01};
        tbl[7] = '{KIND_RR,    4'd2, 2'd2, 2'd0, 2'd3, 8'h00, 8'h00, 2'b01};
        tbl[8] = '{KIND_RR,    4'd4, 2'd1, 2'd0, 2'd1, 8'h00, 8'hA4, 2'b00};
        tbl[9] = '{KIND_RI,    4'd1, 2'd3, 2'd3, 2'd0, 8'h03, 8'hFF, 2'b10};

        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) send(tbl[i]);
        drain();
        chk_reg(2'd0, 8'hA5);
        chk_reg(2'd1, 8'hA4);
        chk_reg(2'd2, 8'h00);
        chk_reg(2'd3, 8'hFF);

        @(negedge clk);
        send('{KIND_LOADI, 4'd0, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 2'b10});
        cmd_valid = 0;
        @(negedge clk);
        send('{KIND_LOADI, 4'd0, 2'd2, 2'd0, 2'd0, 8'h02, 8'h02, 2'b10});
        cmd_valid = 0;
        @(negedge clk);
        send('{KIND_RR, 4'd0, 2'd3, 2'd1, 2'd2, 8'h00, 8'h03, 2'b00});
        cmd_valid = 0;
        @(negedge clk);
        chk("exec_alu_a", 32'(alu_a), 32'h01);
        chk("exec_alu_b", 32'(alu_b), 32'h02);
        chk("exec_alu_op", 32'(alu_op), 32'h0);
        drain();
        repeat (3) @(negedge clk);
        chk("idle_hold_alu_a", 32'(alu_a), 32'h01);
        chk("idle_hold_alu_b", 32'(alu_b), 32'h02);
        chk_reg(2'd3, 8'h03);
        chk_reg(2'd1, 8'h01);

        @(negedge clk);
        send('{KIND_RR, 4'd0, 2'd0, 2'd1, 2'd2, 8'h00, 8'h03, 2'b00});
        @(negedge clk);
        mon_en = 0;
        q.delete();
        rst_n = 0;
        cmd_valid = 0;
        #1;
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;
        chk_reg(2'd0, 8'h00);
        chk_reg(2'd1, 8'h00);
        chk_reg(2'd2, 8'h00);
        chk_reg(2'd3, 8'h00);
        chk("postrst_flags", 32'(flags), 32'd0);
        chk("postrst_res_data", 32'(res_data), 32'd0);
        chk("postrst_res_valid", 32'(res_valid), 32'd0);
        chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
        mon_en = 1;
        @(negedge clk);
        send('{KIND_LOADI, 4'd0, 2'd2, 2'd0, 2'd0, 8'h77, 8'h77, 2'b00});
        drain();
        chk_reg(2'd2, 8'h77);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller that sequences the shared 8-bit ALU of tinyCPU.
- Accepts one command at a time over a valid/ready handshake and fetches operands from an internal register file.
- Drives the ALU ports (A, B, op), captures E and cc, writes the result back and reports completion.
- Sits between the instruction decoder and the ALU instance; the ALU itself stays combinational and external.

Parameters:
- WIDTH, 8, datapath width; matches ALU A/B/E.
- NREGS, 4, number of general registers; must be a power of two.
- AW, 2, register address width; equals log2(NREGS).
- OPW, 4, ALU op code width.
- CCW, 2, ALU condition-code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_kind  in  2  command kind: 0 ALU reg-reg, 1 ALU reg-imm, 2 LOADI, 3 NOP.
- cmd_op  in  OPW  ALU op code.
- cmd_dst  in  AW  destination register.
- cmd_src_a  in  AW  operand A register.
- cmd_src_b  in  AW  operand B register (kind 0 only).
- cmd_imm  in  WIDTH  immediate (kinds 1, 2).
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  OPW  to ALU op.
- alu_e  in  WIDTH  from ALU E.
- alu_cc  in  CCW  from ALU cc.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  WIDTH  value written (held until next completion).
- flags  out  CCW  last ALU cc captured.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  WIDTH  register[dbg_addr], combinational.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, port rst_n.
- Reset values:
  - FSM = IDLE.
  - All registers = 0.
  - alu_a, alu_b, alu_op, res_data, flags = 0.
  - res_valid = 0.
  - cmd_ready = 1 once reset is released.
- FSM states: IDLE, READ, EXEC, WB.
  - cmd_ready = 1 only in IDLE. Handshake = cmd_valid & cmd_ready. All command fields are latched at the handshake.
  - IDLE -> READ on handshake (kinds 0, 1, 2). IDLE -> WB on handshake (kind 3).
  - READ:
    - kinds 0/1: drive registered alu_a = reg[src_a]; alu_b = reg[src_b] (kind 0) or imm (kind 1); alu_op = cmd_op. Next state EXEC.
    - kind 2: go directly to WB.
  - EXEC: ALU settles combinationally. At the end of EXEC, capture alu_e into the result latch and alu_cc into flags. Next state WB.
  - WB:
    - Write reg[dst] (not for NOP) and set res_valid = 1 for exactly one cycle.
    - res_data updates in the same cycle: ALU result, imm for LOADI, unchanged for NOP.
    - Next state IDLE.
- Latency, with the handshake in cycle N:
  - ALU kinds: res_valid in N+3.
  - LOADI: res_valid in N+2.
  - NOP: res_valid in N+1.
  - Next command accepted no earlier than the cycle after res_valid.
- Flags: updated only by ALU kinds. LOADI and NOP leave flags unchanged.
- Operand aliasing: src == dst is legal. Operands are read in READ, before the WB write.
- alu_a, alu_b and alu_op hold their last values outside READ/EXEC, so the ALU does not toggle when idle.
- cmd_valid while busy: ignored, no state change. The source must hold the command until ready.
- Reset mid-operation: the in-flight command is dropped with no partial write. res_valid = 0 immediately (asynchronous reset).
- The cc encoding is opaque to the sequencer; it is stored bit-exact.
- dbg_data reflects a WB write from the cycle after WB.

Optional Feature:
- Macro: ALU_SEQ_OUTREG_EN.
- Defined:
  - Adds state EXEC2 between EXEC and WB. The ALU result and cc are registered at the end of EXEC and committed from that register in EXEC2, to relieve ALU timing.
  - ALU-kind latency becomes N+4. LOADI and NOP latency are unchanged.
- Undefined: the FSM is exactly as above.

Decomposition:
- Package alu_seq_pkg:
  - state encoding constants (IDLE, READ, EXEC, EXEC2, WB);
  - cmd_kind constants (KIND_RR, KIND_RI, KIND_LOADI, KIND_NOP);
  - default widths.
- Sub-module alu_seq_regfile:
  - NREGS x WIDTH registers with async reset to 0;
  - one write port and three combinational read ports (src_a, src_b, dbg).
- FSM and ALU drive stay in the top-level module. The ALU is instantiated beside the block, not inside it.

Test Plan:
- Reset: assert rst_n = 0 mid-EXEC, then release -> all registers read 0 via dbg, flags = 0, res_valid = 0, cmd_ready = 1.
- LOADI r1 = 1, then LOADI r2 = 2 -> each res_valid at N+2 with res_data 1 and 2; dbg reads r1 = 1, r2 = 2; flags unchanged.
- ALU reg-reg op = 0, dst r3, src r1, r2 -> alu_a = 1, alu_b = 2, alu_op = 0 during EXEC; res_valid at N+3; r3 = ALU golden result; flags = ALU cc.
- ALU reg-imm op = 0, src = dst = r3, imm = 8'hFF -> operands use the old r3; wrap result equals ALU golden model; exactly one res_valid pulse.
- Back-to-back: cmd_valid held high with 4 commands -> cmd_ready low while busy, no command lost or duplicated; NOP completes at N+1 with no register change.
- ALU_SEQ_OUTREG_EN defined: repeat the reg-reg case -> res_valid at N+4, same result; LOADI latency still N+2.
